// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit and its buffer.
package instruction_fetch_unit_pkg;

  localparam int unsigned IFU_XLEN       = 32;
  localparam logic [31:0] IFU_RESET_PC   = 32'h0000_0000;
  localparam int unsigned IFU_FIFO_DEPTH = 2;
  localparam int unsigned INST_BYTES     = 4;
  localparam logic [31:0] NOP            = 32'h0000_0013;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Small synchronous FIFO holding fetched {word, pc} pairs.
// Flush wins over push/pop; push while full is accepted only alongside a pop.
module instruction_fetch_unit_fetch_buffer
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata;
        wr_d        = inc(wr_q);
      end
      if (do_pop) begin
        rd_d = inc(rd_q);
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC owner: credit-limited imem requests, response buffering,
// and redirect handling that drops responses still in flight.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN       = IFU_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(IFU_RESET_PC),
  parameter int unsigned     FIFO_DEPTH = IFU_FIFO_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirectValid,
  input  logic [XLEN-1:0] redirectPc,
  output logic            imemReqValid,
  output logic [XLEN-1:0] imemReqAddr,
  input  logic            imemReqReady,
  input  logic            imemRespValid,
  input  logic [XLEN-1:0] imemRespData,
  output logic            instValid,
  output logic [XLEN-1:0] instData,
  output logic [XLEN-1:0] instPc,
  input  logic            instReady
);

  localparam int unsigned     CW   = cnt_width(FIFO_DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(INST_BYTES);
  localparam logic [CW:0]     CAP  = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     occ;
  logic [CW:0]       credit;
  logic [2*XLEN-1:0] head;
  logic [XLEN-1:0]   target;
  logic              buf_full;
  logic              buf_empty;
  logic              accept;
  logic              push;
  logic              pop;
  logic              unused_bits;

  assign unused_bits = ^redirectPc[1:0];
  assign target      = {redirectPc[XLEN-1:2], 2'b00};

  // Buffered plus in-flight never exceeds the buffer depth.
  assign credit       = {1'b0, occ} + {1'b0, outst_q};
  assign imemReqValid = rst_n && !redirectValid && !buf_full
                        && (credit < CAP);
  assign imemReqAddr  = fetch_pc_q;
  assign accept       = imemReqValid && imemReqReady;

  assign push = imemRespValid && (drop_q == '0) && !redirectValid;
  assign pop  = instValid && instReady && !redirectValid;

  assign instValid = !buf_empty;
  assign instData  = head[2*XLEN-1:XLEN];
  assign instPc    = head[XLEN-1:0];

  instruction_fetch_unit_fetch_buffer #(
    .WIDTH (2 * XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirectValid),
    .push  (push),
    .pop   (pop),
    .wdata ({imemRespData, resp_pc_q}),
    .rdata (head),
    .full  (buf_full),
    .empty (buf_empty),
    .count (occ)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + CW'(accept) - CW'(imemRespValid);
    if (redirectValid) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      drop_d     = outst_q - CW'(imemRespValid);
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + STEP;
      end
      if (imemRespValid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          resp_pc_d = resp_pc_q + STEP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: fixed-latency imem model with epoch
// tagging, expected-instruction scoreboard, per-cycle table and corner cases.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectPc = '0;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady = 1'b0;
  logic        imemRespValid = 1'b0;
  logic [31:0] imemRespData = '0;
  logic        instValid;
  logic [31:0] instData;
  logic [31:0] instPc;
  logic        instReady = 1'b0;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .imemReqValid  (imemReqValid),
    .imemReqAddr   (imemReqAddr),
    .imemReqReady  (imemReqReady),
    .imemRespValid (imemRespValid),
    .imemRespData  (imemRespData),
    .instValid     (instValid),
    .instData      (instData),
    .instPc        (instPc),
    .instReady     (instReady)
  );

  typedef struct { logic [31:0] addr; int due; int ep; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct {
    bit rv; logic [31:0] rpc; bit rrdy; bit irdy;
    bit e_req; logic [31:0] e_addr; bit e_iv; logic [31:0] e_pc;
  } vec_t;

  pend_t       pend_q[$];
  exp_t        exp_q[$];
  logic [31:0] seen_q[$];
  int          cyc, lat, epoch, checks, failures;
  bit          resp_live;
  int          resp_ep;
  logic [31:0] resp_addr;
  vec_t        tbl[7];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the negedge, then let outputs settle.
  task automatic drive(input bit rv, input logic [31:0] rpc,
                       input bit rrdy, input bit irdy);
    redirectValid = rv;
    redirectPc    = rpc;
    imemReqReady  = rrdy;
    instReady     = irdy;
    resp_live     = 1'b0;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      imemRespValid = 1'b1;
      imemRespData  = mem_word(pend_q[0].addr);
      resp_live     = 1'b1;
      resp_ep       = pend_q[0].ep;
      resp_addr     = pend_q[0].addr;
      pend_q.delete(0);
    end else begin
      imemRespValid = 1'b0;
      imemRespData  = '0;
    end
    #1;
  endtask

  // Score the handshake, update the model, cross the clock edge.
  task automatic advance();
    exp_t e;
    if (instValid && instReady && !redirectValid) begin
      seen_q.push_back(instPc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual_pc=%0h required=none", instPc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", instPc, e.pc);
        chk("sb_data", instData, e.data);
      end
    end
    if (redirectValid) begin
      exp_q.delete();
      epoch++;
    end
    if (resp_live && resp_ep == epoch)
      exp_q.push_back('{resp_addr, mem_word(resp_addr)});
    if (imemReqValid && imemReqReady)
      pend_q.push_back('{imemReqAddr, cyc + lat, epoch});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    redirectValid = 1'b0;
    redirectPc    = '0;
    imemReqReady  = 1'b0;
    imemRespValid = 1'b0;
    imemRespData  = '0;
    instReady     = 1'b0;
    resp_live     = 1'b0;
    pend_q.delete();
    exp_q.delete();
    seen_q.delete();
    #1;
    chk("rst_req_valid", imemReqValid, 0);
    chk("rst_req_addr", imemReqAddr, 0);
    chk("rst_inst_valid", instValid, 0);
    chk("rst_inst_data", instData, 0);
    chk("rst_inst_pc", instPc, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic wait_valid(input int maxc);
    int n;
    n = 0;
    drive(1'b0, '0, 1'b1, 1'b1);
    while (!instValid && n < maxc) begin
      advance();
      drive(1'b0, '0, 1'b1, 1'b1);
      n++;
    end
    checks++;
    if (!instValid) begin
      failures++;
      $display("FAIL wait_valid actual=timeout required=instValid");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    epoch    = 0;
    lat      = 1;
    cyc      = 0;

    // Steady stream, L=1: credit limit gives a period-3 pattern.
    tbl[0] = '{0, 0, 1, 1, 1, 32'h0,  0, 32'h0};
    tbl[1] = '{0, 0, 1, 1, 1, 32'h4,  0, 32'h0};
    tbl[2] = '{0, 0, 1, 1, 0, 32'h8,  1, 32'h0};
    tbl[3] = '{0, 0, 1, 1, 1, 32'h8,  1, 32'h4};
    tbl[4] = '{0, 0, 1, 1, 1, 32'hC,  0, 32'h0};
    tbl[5] = '{0, 0, 1, 1, 0, 32'h10, 1, 32'h8};
    tbl[6] = '{0, 0, 1, 1, 1, 32'h10, 1, 32'hC};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].rv, tbl[i].rpc, tbl[i].rrdy, tbl[i].irdy);
      chk("t1_req_valid", imemReqValid, tbl[i].e_req);
      chk("t1_req_addr", imemReqAddr, tbl[i].e_addr);
      chk("t1_inst_valid", instValid, tbl[i].e_iv);
      chk("t1_inst_pc", instPc, tbl[i].e_pc);
      chk("t1_inst_data", instData,
          tbl[i].e_iv ? mem_word(tbl[i].e_pc) : 32'h0);
      advance();
    end

    // Decode stall: buffer fills, requests stop, head held.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      if (i >= 3) begin
        chk("t2_hold_valid", instValid, 1);
        chk("t2_hold_req", imemReqValid, 0);
        chk("t2_hold_pc", instPc, 32'h0);
      end
      advance();
    end
    seen_q.delete();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, '0, 1'b1, 1'b1);
      advance();
    end
    chk("t2_seen_cnt", (seen_q.size() >= 3), 1);
    if (seen_q.size() >= 3) begin
      chk("t2_seen0", seen_q[0], 32'h0);
      chk("t2_seen1", seen_q[1], 32'h4);
      chk("t2_seen2", seen_q[2], 32'h8);
    end

    // Redirect with two requests in flight (L=3).
    lat = 3;
    do_reset();
    drive(1'b0, '0, 1'b1, 1'b1);
    advance();
    drive(1'b0, '0, 1'b1, 1'b1);
    advance();
    drive(1'b1, 32'h100, 1'b1, 1'b1);
    chk("t3_redirect_noreq", imemReqValid, 0);
    advance();
    wait_valid(30);
    chk("t3_first_pc", instPc, 32'h100);
    chk("t3_first_data", instData, mem_word(32'h100));
    advance();

    // Redirect to unaligned target while a response lands.
    lat = 1;
    do_reset();
    drive(1'b0, '0, 1'b1, 1'b1);
    advance();
    drive(1'b1, 32'h203, 1'b1, 1'b1);
    chk("t4_resp_same_cycle", imemRespValid, 1);
    chk("t4_redirect_noreq", imemReqValid, 0);
    advance();
    drive(1'b0, '0, 1'b1, 1'b1);
    chk("t4_req_valid", imemReqValid, 1);
    chk("t4_req_addr", imemReqAddr, 32'h200);
    chk("t4_dropped", instValid, 0);
    advance();
    wait_valid(10);
    chk("t4_first_pc", instPc, 32'h200);
    advance();

    // Address wrap at the top of the space.
    drive(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    advance();
    seen_q.delete();
    drive(1'b0, '0, 1'b1, 1'b1);
    chk("t5_addr_top", imemReqAddr, 32'hFFFF_FFFC);
    advance();
    drive(1'b0, '0, 1'b1, 1'b1);
    chk("t5_addr_wrap", imemReqAddr, 32'h0);
    advance();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b1, 1'b1);
      advance();
    end
    chk("t5_seen_cnt", (seen_q.size() >= 2), 1);
    if (seen_q.size() >= 2) begin
      chk("t5_seen0", seen_q[0], 32'hFFFF_FFFC);
      chk("t5_seen1", seen_q[1], 32'h0);
    end

    // Reset while the buffer is full.
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      if (i == 5) begin
        chk("t6_full_valid", instValid, 1);
        chk("t6_full_noreq", imemReqValid, 0);
      end
      if (i < 5) advance();
    end
    do_reset();
    drive(1'b0, '0, 1'b1, 1'b1);
    chk("t6_post_req_valid", imemReqValid, 1);
    chk("t6_post_req_addr", imemReqAddr, 32'h0);
    advance();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, '0, 1'b1, 1'b1);
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
